// File: rtl/mult_mac_ctrl.sv
// Operand-pair sequencer and wide accumulator sitting behind mult32x32_fast.
// Issues each accepted pair to the multiplier and presents the running sum when the last pair completes.
module mult_mac_ctrl #(
   parameter int ACC_W = 72,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic             in_last,
   output logic             mult_start,
   output logic [31:0]      mult_a,
   output logic [31:0]      mult_b,
   input  logic             mult_busy,
   input  logic [63:0]      mult_product,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] pair_cnt,
   output logic             overflow
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_HI,
      WAIT_LO,
      ACCUM,
      OUT
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           last_q;
   logic           take;
   logic [ACC_W:0] sum;

   assign take = (state == IDLE) && in_valid && in_ready;
   assign sum  = {1'b0, acc_out} + {{(ACC_W - 63){1'b0}}, mult_product};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT_HI;
         WAIT_HI: if (mult_busy) state_nxt = WAIT_LO;
         WAIT_LO: if (!mult_busy) state_nxt = ACCUM;
         ACCUM:   state_nxt = last_q ? OUT : IDLE;
         OUT:     if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state, so they are glitch-free and clear under reset.
   // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready   <= 1'b0;
         mult_start <= 1'b0;
         out_valid  <= 1'b0;
         mult_a     <= '0;
         mult_b     <= '0;
         last_q     <= 1'b0;
         acc_out    <= '0;
         pair_cnt   <= '0;
         overflow   <= 1'b0;
      end else begin
         in_ready   <= (state_nxt == IDLE);
         mult_start <= (state_nxt == ISSUE);
         out_valid  <= (state_nxt == OUT);
         if (take) begin
            mult_a <= in_a;
            mult_b <= in_b;
            last_q <= in_last;
         end
         if (state == ACCUM) begin
            acc_out  <= sum[ACC_W-1:0];
            pair_cnt <= pair_cnt + CNT_W'(1);
            if (sum[ACC_W]) overflow <= 1'b1;
         end
         if (state == OUT && out_ready) begin
            acc_out  <= '0;
            pair_cnt <= '0;
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mult_mac_ctrl.sv
// Self-checking bench: a 72-bit and a 64-bit accumulator instance run in lockstep on the same
// stream, each with its own behavioural multiplier; results are compared against tables and a sum model.
module tb_mult_mac_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        drv_valid, in_valid, in_last, out_ready;
   logic [31:0] in_a, in_b;

   logic        rdy_w, rdy_n, start_w, start_n, busy_w, busy_n, ov_w, ov_n, ovf_w, ovf_n;
   logic [31:0] ma_w, mb_w, ma_n, mb_n;
   logic [63:0] prod_w, prod_n;
   logic [71:0] acc_w;
   logic [63:0] acc_n;
   logic [15:0] cnt_w, cnt_n;

   int n_chk = 0;
   int n_pass = 0;
   int lat = 3;

   always #5 clk = ~clk;

   assign in_valid = drv_valid & rdy_w & rdy_n;

   mult_mac_ctrl #(.ACC_W(72), .CNT_W(16)) dut_w (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(rdy_w), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .mult_start(start_w), .mult_a(ma_w), .mult_b(mb_w), .mult_busy(busy_w),
      .mult_product(prod_w), .out_valid(ov_w), .out_ready(out_ready), .acc_out(acc_w),
      .pair_cnt(cnt_w), .overflow(ovf_w)
   );

   mult_mac_ctrl #(.ACC_W(64), .CNT_W(16)) dut_n (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(rdy_n), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .mult_start(start_n), .mult_a(ma_n), .mult_b(mb_n), .mult_busy(busy_n),
      .mult_product(prod_n), .out_valid(ov_n), .out_ready(out_ready), .acc_out(acc_n),
      .pair_cnt(cnt_n), .overflow(ovf_n)
   );

   // Multiplier models: busy for 'lat' cycles after start, junk on the product until busy falls.
   int          rem_w, rem_n;
   logic [63:0] res_w, res_n;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_w <= 1'b0; rem_w <= 0; res_w <= '0; prod_w <= '0;
      end else if (start_w) begin
         busy_w <= 1'b1; rem_w <= lat; res_w <= 64'(ma_w) * 64'(mb_w); prod_w <= {$urandom, $urandom};
      end else if (busy_w) begin
         if (rem_w <= 1) begin busy_w <= 1'b0; prod_w <= res_w; end
         else rem_w <= rem_w - 1;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_n <= 1'b0; rem_n <= 0; res_n <= '0; prod_n <= '0;
      end else if (start_n) begin
         busy_n <= 1'b1; rem_n <= lat; res_n <= 64'(ma_n) * 64'(mb_n); prod_n <= {$urandom, $urandom};
      end else if (busy_n) begin
         if (rem_n <= 1) begin busy_n <= 1'b0; prod_n <= res_n; end
         else rem_n <= rem_n - 1;
      end
   end

   // Protocol monitors: start pulse shape, operand stability while busy, ready/valid exclusivity.
   int          start_cnt = 0, dbl_err = 0, stab_err = 0, excl_err = 0;
   logic        start_prev = 1'b0;
   logic [31:0] cap_aw, cap_bw, cap_an, cap_bn;

   always @(negedge clk) begin
      if (rst) begin
         start_prev <= 1'b0;
      end else begin
         start_prev <= start_w;
         if (start_w) begin
            start_cnt <= start_cnt + 1;
            cap_aw <= ma_w; cap_bw <= mb_w; cap_an <= ma_n; cap_bn <= mb_n;
         end
         if ((start_w && start_prev) || (start_w != start_n)) dbl_err <= dbl_err + 1;
         if ((busy_w && (ma_w != cap_aw || mb_w != cap_bw)) ||
             (busy_n && (ma_n != cap_an || mb_n != cap_bn))) stab_err <= stab_err + 1;
         if ((ov_w && rdy_w) || (ov_n && rdy_n)) excl_err <= excl_err + 1;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic bit any_out();
      return |{rdy_w, rdy_n, start_w, start_n, ma_w, mb_w, ma_n, mb_n, ov_w, ov_n,
               acc_w, acc_n, cnt_w, cnt_n, ovf_w, ovf_n};
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      drv_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input bit last, output bit ok);
      int t = 0;
      while (!(rdy_w && rdy_n) && t < 500) begin
         @(posedge clk); #1; t++;
      end
      ok = rdy_w && rdy_n;
      if (!ok) begin
         check("ready_wait", {rdy_w, rdy_n}, 2'b11);
         return;
      end
      drv_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      @(posedge clk); #1;
      drv_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_last = 1'($urandom);
   endtask

   task automatic run_seq(input string tag, input int n, input logic [7:0][31:0] a,
                          input logic [7:0][31:0] b, input int hold, input bit early,
                          input logic [71:0] ew, input logic [63:0] en, input bit eow, input bit eon);
      int  sb, db, stb, xb, t, bad;
      bit  ok;
      sb = start_cnt; db = dbl_err; stb = stab_err; xb = excl_err;
      for (int i = 0; i < n; i++) begin
         send_pair(a[i], b[i], (i == n - 1), ok);
         if (!ok) begin apply_reset(); return; end
      end
      out_ready = early;
      t = 0;
      while (!(ov_w && ov_n) && t < 500) begin
         @(posedge clk); #1; t++;
      end
      check({tag, "_valid"}, {ov_w, ov_n}, 2'b11);
      if (!(ov_w && ov_n)) begin apply_reset(); return; end
      check({tag, "_acc72"}, acc_w, ew);
      check({tag, "_acc64"}, acc_n, en);
      check({tag, "_ovf"}, {ovf_w, ovf_n}, {eow, eon});
      check({tag, "_cnt"}, {cnt_w, cnt_n}, {16'(n), 16'(n)});
      if (!early) begin
         bad = 0;
         repeat (hold) begin
            @(posedge clk); #1;
            if (!ov_w || !ov_n || rdy_w || rdy_n || acc_w != ew || acc_n != en ||
                cnt_w != 16'(n) || cnt_n != 16'(n) || ovf_w != eow || ovf_n != eon) bad++;
         end
         if (hold > 0) check({tag, "_hold"}, bad, 0);
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_accept"}, {ov_w, ov_n, rdy_w, rdy_n}, 4'b0011);
      check({tag, "_cleared"}, |{acc_w, acc_n, cnt_w, cnt_n, ovf_w, ovf_n}, 1'b0);
      check({tag, "_starts"}, start_cnt - sb, n);
      check({tag, "_protocol"}, {dbl_err - db, stab_err - stb, excl_err - xb}, '0);
   endtask

   typedef struct {
      string             name;
      int                n;
      logic [7:0][31:0]  a;
      logic [7:0][31:0]  b;
      int                hold;
      bit                early;
      logic [71:0]       exp_w;
      logic [63:0]       exp_n;
      bit                ovf_w;
      bit                ovf_n;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [127:0]     tot;
      logic [7:0][31:0] ra, rb;
      int               n, t;
      bit               ok;

      tbl[0] = '{"single", 1, {224'd0, 32'd313552739}, {224'd0, 32'd207231267}, 0, 1'b0,
                 72'd64977931374290313, 64'd64977931374290313, 1'b0, 1'b0};
      tbl[1] = '{"two", 2, {192'd0, 32'h6F63, 32'd313552739}, {192'd0, 32'h1923, 32'd207231267}, 0, 1'b0,
                 72'd64977931557784338, 64'd64977931557784338, 1'b0, 1'b0};
      tbl[2] = '{"max2", 2, {192'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, {192'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 0, 1'b0,
                 72'h1_FFFF_FFFC_0000_0002, 64'hFFFF_FFFC_0000_0002, 1'b0, 1'b1};
      tbl[3] = '{"one", 1, {224'd0, 32'd1}, {224'd0, 32'd1}, 0, 1'b1, 72'd1, 64'd1, 1'b0, 1'b0};
      tbl[4] = '{"hold10", 1, {224'd0, 32'd313552739}, {224'd0, 32'd207231267}, 10, 1'b0,
                 72'd64977931374290313, 64'd64977931374290313, 1'b0, 1'b0};

      rst = 1'b1; drv_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1 check("reset_outputs", any_out(), 1'b0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("reset_release", {rdy_w, rdy_n, ov_w, ov_n, start_w, acc_w, cnt_w, ovf_w}, {4'b1100, 1'b0, 72'd0, 16'd0, 1'b0});

      foreach (tbl[i]) begin
         lat = 3 + i;
         run_seq(tbl[i].name, tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].early,
                 tbl[i].exp_w, tbl[i].exp_n, tbl[i].ovf_w, tbl[i].ovf_n);
      end

      // Reset while the second pair is in flight, then a fresh single pair must start from zero.
      lat = 5;
      send_pair(32'd7, 32'd9, 1'b0, ok);
      if (ok) send_pair(32'd11, 32'd13, 1'b1, ok);
      t = 0;
      while (!busy_w && t < 100) begin
         @(posedge clk); #1; t++;
      end
      @(posedge clk); #1;
      check("mid_live", {acc_w, cnt_w, busy_w}, {72'd63, 16'd1, 1'b1});
      #2 rst = 1'b1;
      #1 check("mid_reset", any_out(), 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      run_seq("after_rst", 1, {224'd0, 32'd3}, {224'd0, 32'd5}, 0, 1'b0, 72'd15, 64'd15, 1'b0, 1'b0);

      // Randomized sequences against an arbitrary-precision sum model.
      for (int s = 0; s < 20; s++) begin
         n   = $urandom_range(1, 6);
         lat = $urandom_range(1, 6);
         ra  = '0; rb = '0; tot = '0;
         for (int i = 0; i < n; i++) begin
            ra[i] = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb[i] = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
            tot   = tot + 128'(ra[i]) * 128'(rb[i]);
         end
         run_seq("rand", n, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 tot[71:0], tot[63:0], |tot[127:72], |tot[127:64]);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mult_mac_ctrl.md
Name: mult_mac_ctrl

Overview:
- Sequencer and accumulator directly downstream of mult32x32_fast.
- Accepts a stream of 32-bit operand pairs over a valid/ready handshake and issues each pair to the multiplier using its start/busy protocol.
- Sums the 64-bit products into a wide accumulator and presents the total, with a pair count and a sticky overflow flag, when the pair marked last completes.
- Provides dot-product / MAC capability on top of the existing multiplier.

Parameters:
- ACC_W, 72, accumulator and result width in bits; must be >= 64.
- CNT_W, 16, pair-counter width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair available
- in_ready  output  1  block can accept a pair
- in_a  input  32  operand a, unsigned
- in_b  input  32  operand b, unsigned
- in_last  input  1  current pair is the final pair of the sequence
- mult_start  output  1  one-cycle start pulse to the multiplier
- mult_a  output  32  operand a to the multiplier
- mult_b  output  32  operand b to the multiplier
- mult_busy  input  1  multiplier busy
- mult_product  input  64  multiplier result, valid once busy falls
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- acc_out  output  ACC_W  accumulated sum
- pair_cnt  output  CNT_W  number of pairs in the sum
- overflow  output  1  sticky: some addition carried out of ACC_W

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All of the following clear to 0: in_ready, mult_start, mult_a, mult_b, out_valid, acc_out, pair_cnt, overflow, and the internal last flag.
- IDLE: in_ready=1.
  - On in_valid&in_ready: latch in_a/in_b into mult_a/mult_b and latch in_last.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle): mult_start=1, in_ready=0. Go to WAIT_HI.
- WAIT_HI: wait for mult_busy=1, then go to WAIT_LO. There is no timeout.
- WAIT_LO: on the first cycle with mult_busy=0, go to ACCUM.
- ACCUM (1 cycle):
  - acc <= acc + zero-extended mult_product, computed to ACC_W+1 bits.
  - Bit ACC_W of that sum sets overflow (sticky); acc keeps the low ACC_W bits.
  - pair_cnt <= pair_cnt + 1, wrapping modulo 2^CNT_W with no flag.
  - If the last flag is set, go to OUT; otherwise go to IDLE.
- OUT: out_valid=1. acc_out, pair_cnt and overflow are held stable.
  - On out_ready: clear acc, pair_cnt, overflow and out_valid, then go to IDLE.
  - out_ready held high in advance completes in the first OUT cycle.
- acc_out and pair_cnt are always driven from the live registers, so they are observable mid-sequence. They are only defined as a result while out_valid=1.
- mult_a/mult_b hold their value from ISSUE through ACCUM and are not changed while mult_busy=1.
- Inputs are ignored while in_ready=0. in_last applies only at the handshake cycle.
- Throughput: one pair per (multiplier latency + 3) cycles. The last pair costs one additional cycle plus the out_ready wait.
- in_ready and out_valid are never asserted simultaneously.
- Single pair with in_last=1: result = that product, pair_cnt=1.

Test Plan:
- Reset held 4 cycles, then released → all outputs 0, in_ready=1.
- Single pair a=313552739, b=207231267, last=1 → mult_start high for exactly one cycle; out_valid with acc_out=64977931374290313, pair_cnt=1, overflow=0.
- Two pairs, (313552739, 207231267) then (0x6F63, 0x1923, last) → acc_out=64977931557784338, pair_cnt=2. Check mult_a/mult_b stable while busy.
- ACC_W=64 instance, two pairs 0xFFFFFFFF×0xFFFFFFFF → acc_out=0xFFFFFFFC00000002, overflow=1. The next sequence of 1×1, last → acc_out=1, overflow=0.
- Hold out_ready=0 for 10 cycles on a completed result → out_valid, acc_out, pair_cnt stable and in_ready=0; accepted on the first cycle out_ready=1, then in_ready=1 the next cycle.
- Assert reset during WAIT_LO of the second pair → immediate return to IDLE with all outputs 0. A following single pair 3×5 → acc_out=15, pair_cnt=1.
